// File: rtl/alu_seq_mul_pkg.sv
// Shared definitions for the sequential multiply ALU slice.
//   WIDTH       operand/result width
//   CNT_W       width of the step counter
//   FUNCT_MULT  function code selecting unsigned multiply
//   state_t     control FSM states
package alu_seq_mul_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [5:0] FUNCT_MULT = 6'b001001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul_if.sv
// Start/done request bus of the multiply ALU slice.
//   Start        one-cycle request, samples Src1/Src2/Funct
//   Src1, Src2   multiplicand, multiplier
//   Funct        function code
//   Result       low product bits (0 for unsupported codes)
//   Carry        set when the upper product half is nonzero
//   Busy         operation in progress
//   Done         one-cycle completion pulse
// master = requester, slave = ALU slice.
interface alu_seq_mul_if;
    import alu_seq_mul_pkg::*;

    logic             Start;
    logic [WIDTH-1:0] Src1;
    logic [WIDTH-1:0] Src2;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] Result;
    logic             Carry;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Src1, Src2, Funct,
        input  Result, Carry, Busy, Done
    );

    modport slave (
        input  Start, Src1, Src2, Funct,
        output Result, Carry, Busy, Done
    );

endinterface

// File: rtl/alu_mul_datapath.sv
// Shift-add multiply datapath: 64-bit accumulator, multiplier shift
// register and step counter.
//   clk, rst_n   clock, synchronous active-low reset
//   load         latch operands, clear accumulator and counter
//   step         perform one shift-add step
//   mcand_in     multiplicand to latch
//   mplr_in      multiplier to latch
//   acc          accumulator (full product after WIDTH steps)
//   last         current step is the final one
module alu_mul_datapath
    import alu_seq_mul_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplr_in,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum;

    // Upper-half partial sum keeps the carry-out as bit WIDTH.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (mplr[0])
            sum = sum + {1'b0, mcand};
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= mcand_in;
            mplr  <= mplr_in;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            // {carry, sum, acc_low} shifted right by one position
            acc  <= {sum, acc[WIDTH-1:1]};
            mplr <= mplr >> 1;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq_mul.sv
// Sequential multiply ALU slice with start/done handshake.
//   clk, rst_n   clock, synchronous active-low reset
//   bus          request bus (slave side): Start/Src1/Src2/Funct in,
//                Result/Carry/Busy/Done out
// MULT completes 33 clocks after the Start edge, unsupported codes
// complete 1 clock after with a zero result.
//
// state  | meaning
// IDLE   | waiting for Start
// RUN    | one shift-add step per cycle, WIDTH steps
// FINISH | register Result/Carry, pulse Done
module alu_seq_mul
    import alu_seq_mul_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_mul_if.slave  bus
);

    state_t               state;
    state_t               state_nxt;
    logic                 load;
    logic                 step;
    logic                 is_mult;
    logic [2*WIDTH-1:0]   acc;
    logic                 last;
    logic [WIDTH-1:0]     result_q;
    logic                 carry_q;
    logic                 done_q;

    alu_mul_datapath u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .mcand_in (bus.Src1),
        .mplr_in  (bus.Src2),
        .acc      (acc),
        .last     (last)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.Funct == FUNCT_MULT) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = FINISH;
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (last)
                    state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_mult  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == FINISH);
            if (state == IDLE && bus.Start)
                is_mult <= (bus.Funct == FUNCT_MULT);
            if (state == FINISH) begin
                result_q <= is_mult ? acc[WIDTH-1:0] : '0;
                carry_q  <= is_mult ? (|acc[2*WIDTH-1:WIDTH]) : 1'b0;
            end
        end
    end

    assign bus.Result = result_q;
    assign bus.Carry  = carry_q;
    assign bus.Done   = done_q;
    assign bus.Busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_seq_mul.sv
module tb_alu_seq_mul;

    localparam logic [5:0] F_MULT = 6'b001001;
    localparam int         BOUND  = 100;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_seq_mul_if bus ();

    alu_seq_mul dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width unsigned product, split into low half and an
    // overflow flag; unsupported codes give zero.
    function automatic void model(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic c);
        longint unsigned p;
        if (f == F_MULT) begin
            p = longint'(a) * longint'(b);
            r = p[31:0];
            c = (p >> 32) != 0;
        end else begin
            r = '0;
            c = 1'b0;
        end
    endfunction

    // Issue one request and wait for Done. Operands are scrambled right
    // after the Start edge so late changes would show up as wrong results.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output logic c, output int lat);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Funct = f;
        bus.Src1  = a;
        bus.Src2  = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.Src1  = $urandom;
        bus.Src2  = $urandom;
        bus.Funct = 6'($urandom);
        lat = 0;
        while (lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.Done) break;
        end
        if (!bus.Done) lat = -1;
        r = bus.Result;
        c = bus.Carry;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.Start = 1'b0;
        bus.Src1  = '0;
        bus.Src2  = '0;
        bus.Funct = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.Result !== 32'h0 || bus.Carry !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset: Result=%h Carry=%b Busy=%b Done=%b required 0/0/0/0",
                     bus.Result, bus.Carry, bus.Busy, bus.Done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [5:0]  f  [6] = '{F_MULT, F_MULT, F_MULT, F_MULT, F_MULT, 6'b000000};
        logic [31:0] a  [6] = '{32'h0F0F0F1F, 32'h200, 32'hFFFFFFFF, 32'h0, 32'h12345678, 32'h10};
        logic [31:0] b  [6] = '{32'hF0F0F0F0, 32'h1800, 32'hFFFFFFFF, 32'h12345678, 32'h0, 32'h20};
        logic [31:0] er [6] = '{32'h795B3D10, 32'h00300000, 32'h00000001, 32'h0, 32'h0, 32'h0};
        logic        ec [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int          el [6] = '{33, 33, 33, 33, 33, 1};
        logic [31:0] r;
        logic        c;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(f[i], a[i], b[i], r, c, lat);
            checks++;
            if (lat !== el[i]) begin
                errors++;
                $display("FAIL directed%0d latency: got %0d required %0d", i, lat, el[i]);
            end
            checks++;
            if (r !== er[i] || c !== ec[i]) begin
                errors++;
                $display("FAIL directed%0d result: got %h/%b required %h/%b", i, r, c, er[i], ec[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d done_pulse: Done=%b Busy=%b required 0/0", i, bus.Done, bus.Busy);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  f;
        logic [31:0] a, b, r, er;
        logic        c, ec;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : F_MULT;
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) begin
                a = a & 32'h0000FFFF;
                b = b & 32'h0000FFFF;
            end
            model(f, a, b, er, ec);
            run_op(f, a, b, r, c, lat);
            checks++;
            if (lat !== ((f == F_MULT) ? 33 : 1) || r !== er || c !== ec) begin
                errors++;
                $display("FAIL random%0d f=%b a=%h b=%h: got %h/%b lat %0d required %h/%b",
                         i, f, a, b, r, c, lat, er, ec);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] a = 32'hDEADBEEF, b = 32'h00C0FFEE, er;
        logic        ec;
        int          lat;
        bit          seen_busy = 1;
        model(F_MULT, a, b, er, ec);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Funct = F_MULT;
        bus.Src1  = a;
        bus.Src2  = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        lat = 0;
        while (lat < BOUND) begin
            if (lat == 5) begin
                bus.Start = 1'b1;
                bus.Src1  = 32'h11111111;
                bus.Src2  = 32'h22222222;
            end else if (lat == 6) begin
                bus.Start = 1'b0;
            end
            if (lat < 33 && !bus.Busy) seen_busy = 0;
            @(posedge clk);
            #1;
            lat++;
            if (bus.Done) break;
        end
        checks++;
        if (!seen_busy) begin
            errors++;
            $display("FAIL busy_level: Busy dropped before completion, required 1 throughout");
        end
        checks++;
        if (!bus.Done || lat != 33 || bus.Result !== er || bus.Carry !== ec) begin
            errors++;
            $display("FAIL start_while_busy: got %h/%b lat %0d required %h/%b lat 33",
                     bus.Result, bus.Carry, lat, er, ec);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_extra_op: Done=%b Busy=%b required 0/0", bus.Done, bus.Busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Funct = F_MULT;
        bus.Src1  = 32'hFFFFFFFF;
        bus.Src2  = 32'h00000003;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.Result !== 32'h0 || bus.Carry !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: Result=%h Carry=%b Busy=%b Done=%b required 0/0/0/0",
                     bus.Result, bus.Carry, bus.Busy, bus.Done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_abort: %0d cycles with Done/Busy after reset, required 0", done_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, er;
        logic        c, ec;
        int          lat;
        // Start accepted in the cycle Done is high (slice is already idle).
        run_op(F_MULT, 32'h00010001, 32'h00010001, r, c, lat);
        bus.Start = 1'b1;
        bus.Funct = 6'b100000;
        bus.Src1  = 32'h5;
        bus.Src2  = 32'h6;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.Done !== 1'b1 || bus.Result !== 32'h0 || bus.Carry !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_unsup: Done=%b Result=%h Carry=%b required 1/0/0",
                     bus.Done, bus.Result, bus.Carry);
        end
        model(F_MULT, 32'h89ABCDEF, 32'h7, er, ec);
        run_op(F_MULT, 32'h89ABCDEF, 32'h7, r, c, lat);
        checks++;
        if (lat != 33 || r !== er || c !== ec) begin
            errors++;
            $display("FAIL back_to_back_mult: got %h/%b lat %0d required %h/%b", r, c, lat, er, ec);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
